// File: rtl/tpu_mac.sv
// Single-lane unsigned multiply-accumulate with strobe-latched output and sticky overflow flag.
// Define TPU_MAC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module tpu_mac #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             out_HL,
  input  logic [IN_W-1:0]  input1,
  input  logic [IN_W-1:0]  input2,
  output logic [ACC_W-1:0] out,
  output logic             error
);

  logic [2*IN_W-1:0] prod;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_upd;

  always_comb begin
    prod = input1 * input2;
    sum  = {1'b0, acc} + {{(ACC_W+1-2*IN_W){1'b0}}, prod};
`ifdef TPU_MAC_SATURATE_EN
    acc_upd = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    acc_upd = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      out   <= '0;
      error <= 1'b0;
    end else begin
      acc <= acc_upd;
      if (out_HL)
        out <= acc_upd;
      if (sum[ACC_W])
        error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tpu_mac.sv
// Directed plus randomized bench for tpu_mac against an integer-arithmetic reference model.
module tb_tpu_mac;
  localparam int ACC_W   = 17;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        out_HL;
  logic [7:0]  input1, input2;
  logic [16:0] out;
  logic        error;

  int tests = 0;
  int fails = 0;

  int acc_m = 0;
  int out_m = 0;
  int err_m = 0;

  tpu_mac #(.IN_W(8), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .out_HL(out_HL),
    .input1(input1), .input2(input2), .out(out), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_out"}, out, 17'(out_m));
    check({tag, "_err"}, {16'b0, error}, 17'(err_m));
  endtask

  // One clock edge of stimulus; model follows the arithmetic rules directly.
  task automatic step(input int a, input int b, input bit hl, input string tag);
    int n;
    input1 = 8'(a);
    input2 = 8'(b);
    out_HL = hl;
    @(posedge clk);
    n = acc_m + a * b;
    if (n > ACC_MAX) begin
      err_m = 1;
`ifdef TPU_MAC_SATURATE_EN
      n = ACC_MAX;
`else
      n = n - (ACC_MAX + 1);
`endif
    end
    acc_m = n;
    if (hl) out_m = n;
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    acc_m = 0; out_m = 0; err_m = 0;
    check_model("reset_hold");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; out_HL = 1'b0; input1 = '0; input2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("por_out", out, 17'd0);
    check("por_err", {16'b0, error}, 17'd0);
    reset = 1'b0;

    step(13, 15, 1'b1, "single_mac");
    check("single_mac_const", out, 17'd195);

    do_reset();
    step(13, 15, 1'b0, "run_a");
    step(41, 47, 1'b1, "run_b");
    check("running_sum_const", out, 17'd2122);
    step(0, 0, 1'b1, "strobe_noclear");
    for (int i = 0; i < 3; i++) step(1, 1, 1'b0, "hold");
    check("hold_const", out, 17'd2122);
    step(0, 0, 1'b1, "strobe_again");
    check("strobe_again_const", out, 17'd2125);

    // Asynchronous reset landing mid-cycle with a nonzero accumulator.
    #3;
    reset = 1'b1;
    #1;
    acc_m = 0; out_m = 0; err_m = 0;
    check_model("async_reset");
    input1 = 8'd13; input2 = 8'd15; out_HL = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_model("reset_held");
    end
    reset = 1'b0;

    step(255, 255, 1'b1, "ovf_1");
    check("ovf_1_const", out, 17'd65025);
    step(255, 255, 1'b1, "ovf_2");
    check("ovf_2_const", out, 17'd130050);
    step(255, 255, 1'b1, "ovf_3");
`ifdef TPU_MAC_SATURATE_EN
    check("ovf_3_const", out, 17'd131071);
`else
    check("ovf_3_const", out, 17'd64003);
`endif
    check("ovf_3_err", {16'b0, error}, 17'd1);
    step(255, 255, 1'b1, "ovf_4");
    for (int i = 0; i < 3; i++) step(0, 0, 1'b1, "sticky");
    check("sticky_const", {16'b0, error}, 17'd1);
    do_reset();

    for (int i = 0; i < 300; i++) begin
      int a, b;
      if ($urandom_range(0, 39) == 0) do_reset();
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      end else begin
        a = $urandom_range(0, 15); b = $urandom_range(0, 15);
      end
      step(a, b, 1'($urandom_range(0, 1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
